// File: rtl/operand_sequencer_pkg.sv
// Shared opcode and FSM state encodings for the operand sequencer and its ALU-side consumers.
// Pure declarations; no timing or flow-control content.
package operand_sequencer_pkg;

    localparam int OPCODE_W = 4;
    localparam int STATE_W  = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_SHL  = 4'h2,
        OP_SHR  = 4'h3,
        OP_CMP  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_NAND = 4'h8,
        OP_NOR  = 4'h9,
        OP_XNOR = 4'hA,
        OP_INV  = 4'hB,
        OP_NEG  = 4'hC,
        OP_STO  = 4'hD,
        OP_SWP  = 4'hE,
        OP_LOAD = 4'hF
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/operand_sequencer_btn_debounce.sv
// Pushbutton conditioner: 2-FF sync, DEBOUNCE_CYCLES stability counter, one-cycle press on rising level.
// Latency 2 + DEBOUNCE_CYCLES edges from a clean input edge to press; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_in;
            sync_2 <= sync_1;
            press  <= 1'b0;
            // Any cycle where the synced input agrees with the level restarts the count.
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_2;
                    cnt   <= '0;
                    press <= sync_2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Button-driven operand loader: A, then B+opcode, then a valid/ready handshake with result writeback.
// exec_valid rises 1 cycle after the B press and holds until exec_ready; writeback lands 1 cycle after the handshake.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WIDTH           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_enter,
    input  logic [WIDTH-1:0] data_sw,
    input  logic [3:0]       op_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             exec_ready,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] b_reg,
    output logic [3:0]       op_reg,
    output logic             exec_valid,
    output logic [WIDTH-1:0] y_reg,
    output logic [1:0]       state_o
);

    state_e state;
    logic   press;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (btn_enter),
        .press   (press)
    );

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= LOAD_A;
            a_reg      <= '0;
            b_reg      <= '0;
            y_reg      <= '0;
            op_reg     <= '0;
            exec_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press) begin
                        a_reg <= data_sw;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_reg      <= data_sw;
                        op_reg     <= op_sel;
                        exec_valid <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Presses are dropped here; only the handshake moves the FSM on.
                    if (exec_valid && exec_ready) begin
                        exec_valid <= 1'b0;
                        state      <= DONE;
                        case (opcode_e'(op_reg))
                            OP_STO: begin
                                y_reg <= alu_result;
                                a_reg <= alu_result;
                            end
                            OP_SWP: begin
                                a_reg <= b_reg;
                                b_reg <= a_reg;
                                y_reg <= b_reg;
                            end
                            OP_LOAD: begin
                                a_reg <= data_sw;
                                y_reg <= data_sw;
                            end
                            default: begin
                                y_reg <= alu_result;
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (press) begin
                        state <= LOAD_A;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_operand_sequencer;

    localparam int DB = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         btn_enter;
    logic [W-1:0] data_sw;
    logic [3:0]   op_sel;
    logic [W-1:0] alu_result;
    logic         exec_ready;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [3:0]   op_reg;
    logic         exec_valid;
    logic [W-1:0] y_reg;
    logic [1:0]   state_o;

    int errors = 0;
    int checks = 0;

    operand_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .WIDTH           (W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_enter  (btn_enter),
        .data_sw    (data_sw),
        .op_sel     (op_sel),
        .alu_result (alu_result),
        .exec_ready (exec_ready),
        .a_reg      (a_reg),
        .b_reg      (b_reg),
        .op_reg     (op_reg),
        .exec_valid (exec_valid),
        .y_reg      (y_reg),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hold long enough for sync + debounce + FSM edge, then release and let the level settle low.
    task automatic press_btn();
        btn_enter = 1'b1;
        tick(DB + 4);
        btn_enter = 1'b0;
        tick(DB + 4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        btn_enter  = 1'b0;
        data_sw    = '0;
        op_sel     = '0;
        alu_result = '0;
        exec_ready = 1'b0;
        tick(2);
        check("rst_state", state_o, 0);
        check("rst_a", a_reg, 0);
        check("rst_b", b_reg, 0);
        check("rst_y", y_reg, 0);
        check("rst_op", op_reg, 0);
        check("rst_valid", exec_valid, 0);
        reset_n = 1'b1;
        tick(1);

        // Short glitch must not register as a press.
        data_sw   = 8'hEE;
        btn_enter = 1'b1;
        tick(2);
        btn_enter = 1'b0;
        tick(12);
        check("glitch_state", state_o, 0);
        check("glitch_a", a_reg, 0);

        // ADD: 0x12 + 0x05, with exact latency on the B press.
        data_sw = 8'h12;
        press_btn();
        check("add_a", a_reg, 8'h12);
        check("add_state_b", state_o, 1);
        data_sw   = 8'h05;
        op_sel    = 4'h0;
        btn_enter = 1'b1;
        tick(DB + 2);
        check("add_valid_pre", exec_valid, 0);
        check("add_state_pre", state_o, 1);
        tick(1);
        check("add_valid_lat", exec_valid, 1);
        check("add_state_exec", state_o, 2);
        check("add_b", b_reg, 8'h05);
        btn_enter = 1'b0;
        tick(DB + 4);
        alu_result = 8'h17;
        exec_ready = 1'b1;
        tick(1);
        exec_ready = 1'b0;
        check("add_y", y_reg, 8'h17);
        check("add_state_done", state_o, 3);
        check("add_valid_clr", exec_valid, 0);
        check("add_a_keep", a_reg, 8'h12);
        press_btn();
        check("done_to_loada", state_o, 0);
        check("done_keep_y", y_reg, 8'h17);

        // SWP
        data_sw = 8'h3C;
        press_btn();
        data_sw = 8'hA5;
        op_sel  = 4'hE;
        press_btn();
        alu_result = 8'h55;
        exec_ready = 1'b1;
        tick(1);
        exec_ready = 1'b0;
        check("swp_a", a_reg, 8'hA5);
        check("swp_b", b_reg, 8'h3C);
        check("swp_y", y_reg, 8'hA5);
        press_btn();

        // Stall in EXEC with presses that must be dropped.
        data_sw = 8'h21;
        press_btn();
        data_sw = 8'h09;
        op_sel  = 4'h1;
        press_btn();
        tick(20);
        data_sw = 8'h44;
        op_sel  = 4'h7;
        press_btn();
        press_btn();
        check("stall_valid", exec_valid, 1);
        check("stall_state", state_o, 2);
        check("stall_a", a_reg, 8'h21);
        check("stall_b", b_reg, 8'h09);
        check("stall_op", op_reg, 4'h1);
        alu_result = 8'h18;
        exec_ready = 1'b1;
        tick(1);
        exec_ready = 1'b0;
        check("stall_y", y_reg, 8'h18);
        check("stall_done", state_o, 3);
        tick(20);
        check("stall_no_queue", state_o, 3);
        alu_result = 8'hC3;
        exec_ready = 1'b1;
        tick(3);
        exec_ready = 1'b0;
        check("ready_idle_y", y_reg, 8'h18);
        check("ready_idle_state", state_o, 3);
        press_btn();

        // LOAD takes data_sw at the handshake, not at the B press.
        data_sw = 8'h10;
        press_btn();
        data_sw = 8'h33;
        op_sel  = 4'hF;
        press_btn();
        data_sw    = 8'h6E;
        alu_result = 8'h00;
        exec_ready = 1'b1;
        tick(1);
        exec_ready = 1'b0;
        check("load_a", a_reg, 8'h6E);
        check("load_y", y_reg, 8'h6E);
        check("load_b", b_reg, 8'h33);
        press_btn();

        // STO then reload A
        data_sw = 8'h40;
        press_btn();
        data_sw = 8'h3F;
        op_sel  = 4'hD;
        press_btn();
        alu_result = 8'h7F;
        exec_ready = 1'b1;
        tick(1);
        exec_ready = 1'b0;
        check("sto_a", a_reg, 8'h7F);
        check("sto_y", y_reg, 8'h7F);
        press_btn();
        check("sto_loada", state_o, 0);
        check("sto_a_keep", a_reg, 8'h7F);
        data_sw = 8'h01;
        press_btn();
        check("reload_a", a_reg, 8'h01);
        check("reload_state", state_o, 1);

        // Reset in EXEC with ready high: no writeback.
        data_sw = 8'h02;
        op_sel  = 4'h0;
        press_btn();
        check("pre_rst_exec", state_o, 2);
        alu_result = 8'h99;
        exec_ready = 1'b1;
        reset_n    = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("exec_rst_state", state_o, 0);
        check("exec_rst_valid", exec_valid, 0);
        check("exec_rst_y", y_reg, 0);
        check("exec_rst_a", a_reg, 0);
        check("exec_rst_b", b_reg, 0);
        check("exec_rst_op", op_reg, 0);
        tick(1);
        check("exec_rst_y_after", y_reg, 0);
        exec_ready = 1'b0;

        // Button held through reset release yields one press after the debounce window.
        reset_n   = 1'b0;
        btn_enter = 1'b1;
        tick(3);
        reset_n = 1'b1;
        data_sw = 8'h5A;
        tick(DB + 1);
        check("held_early", state_o, 0);
        tick(2);
        check("held_press", state_o, 1);
        check("held_a", a_reg, 8'h5A);
        tick(20);
        check("held_once", state_o, 1);
        btn_enter = 1'b0;
        tick(DB + 4);
        check("held_release", state_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
